maquina_io_port: RTL and testbench
==================================

// Module: maquina_io_port
// PURPOSE
//  I/O port stage driven by the control unit during its IN and OUT execute states.
//  OUT: the datapath word is pushed into a small output FIFO, which drains to an
//  external peripheral over a valid/ready link.
//  IN: a word from the external peripheral, held in a one-entry holding register,
//  is presented to the datapath bus for the memory write.
// PARAMETERS
//  WORD_W      16  datapath word width
//  OUT_DEPTH   4   output FIFO depth in words; power of 2, >=2
//  CNT_W       8   width of the saturating drop/underrun counters
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  out_we       in   1        OUT-state strobe from control unit; push dbus_in
//  in_re        in   1        IN-state strobe from control unit; consume holding reg
//  dbus_in      in   WORD_W   datapath word to output
//  dbus_out     out  WORD_W   holding-reg word to datapath (valid same cycle as in_re)
//  pout_data    out  WORD_W   external output data (FIFO head)
//  pout_valid   out  1        FIFO non-empty
//  pout_ready   in   1        peripheral accepts pout_data
//  pin_data     in   WORD_W   external input data
//  pin_valid    in   1        peripheral offers pin_data
//  pin_ready    out  1        holding register empty
//  out_full     out  1        FIFO full
//  in_avail     out  1        holding register full
//  drop_cnt     out  CNT_W    out_we pushes lost to a full FIFO (saturating)
//  undr_cnt     out  CNT_W    in_re strobes with an empty holding register (saturating)
// BEHAVIOUR
//  Reset (synchronous, active-high; clock clk):
//   - FIFO empty; holding register empty and cleared to 0; both counters 0.
//   - Outputs: pout_valid=0, pin_ready=1, out_full=0, in_avail=0, dbus_out=0.
//  Output FIFO:
//   - Push when out_we && !out_full; pop when pout_valid && pout_ready.
//   - Push and pop in the same cycle are both legal, including when full (pop frees
//     the slot) and when empty (no bypass; the word appears next cycle).
//   - out_we && out_full && !pop: word dropped, drop_cnt++ and saturates at all-ones.
//   - Write and read pointers are log2(OUT_DEPTH)+1 bits wide and wrap naturally.
//   - pout_data = mem[rd_ptr], registered storage, no combinational input path.
//  Input holding register:
//   - Two states, EMPTY and FULL.
//   - EMPTY: pin_ready=1; pin_valid captures pin_data and moves to FULL.
//   - FULL: pin_ready=0; in_re moves to EMPTY.
//   - No same-cycle refill: pin_ready is a pure function of state.
//   - dbus_out = holding register whenever FULL and 0 whenever EMPTY. It is
//     combinational from a flop only, so it is valid within the one-cycle IN state.
//   - in_re while EMPTY: dbus_out=0, undr_cnt++ (saturating), state unchanged.
//   - out_we and in_re asserted together is illegal from the control unit and is not
//     checked; both paths still act independently.
//  Reset mid-operation discards FIFO contents and any held word. No in-flight
//  handshake completes in the reset cycle.
// CONFIGURATION
//  IO_LOOPBACK_EN defined:
//   - Adds input port lb_mode (1 bit).
//   - lb_mode=1: pout_valid forced 0 and pin_ready forced 0 externally. The FIFO head
//     pops into the holding register whenever the holding register is EMPTY and the
//     FIFO is non-empty; a word goes from FIFO head to in_avail=1 in 1 cycle.
//   - Changing lb_mode takes effect the next cycle; no data is lost.
//  IO_LOOPBACK_EN undefined:
//   - No lb_mode port; behaviour is identical to lb_mode=0.
// STRUCTURE
//  Shared package maquina_pkg:
//   - WORD_W.
//   - Control-word bit indices for the io_in/io_out strobes.
//   - Opcode constants OP_IN=4'b1110, OP_OUT=4'b1111, OP_BEQ=4'b1100.
//  Sub-module io_sync_fifo (params W, DEPTH):
//   - push/pop/full/empty/head interface; instanced once for the output path.
//  The holding register FSM stays inline.
// TESTING
//  1 After reset: pout_valid=0, pin_ready=1, dbus_out=0, drop_cnt=0, undr_cnt=0.
//  2 OUT stream, peripheral stalled:
//     - 5 out_we pulses carrying 0x0001..0x0005 with OUT_DEPTH=4, pout_ready=0:
//       out_full=1 after the 4th, drop_cnt=1.
//     - Then pout_ready=1: the peripheral receives 0x0001..0x0004 in order.
//  3 Push and pop together when full: FIFO stays full and the next head is correct.
//     Repeated pushes with a stalled peripheral saturate drop_cnt at 0xFF.
//  4 IN capture:
//     - pin_valid with 0xBEEF: pin_ready=0, in_avail=1 next cycle.
//     - in_re pulse: dbus_out=0xBEEF in that cycle, then in_avail=0 and pin_ready=1.
//  5 IN underrun: in_re while empty gives dbus_out=0 and undr_cnt=1.
//     Reset asserted while FULL and FIFO=3 words: everything empty next cycle.
//  6 With IO_LOOPBACK_EN and lb_mode=1:
//     - out_we 0x1234: in_avail=1 two cycles after the push.
//     - in_re returns 0x1234; pout_valid stays 0 throughout.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared definitions for the maquina CPU: datapath width, control-word strobe
// positions, I/O-related opcodes and the input holding-register state type.
package maquina_pkg;

    localparam int WORD_W = 16;

    // Bit positions of the I/O strobes inside the control word.
    localparam int CTRL_IO_IN_BIT  = 12;
    localparam int CTRL_IO_OUT_BIT = 13;

    localparam logic [3:0] OP_IN  = 4'b1110;
    localparam logic [3:0] OP_OUT = 4'b1111;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // True for the opcodes that drive the I/O port stage.
    function automatic logic is_io_op(input logic [3:0] op);
        return (op == OP_IN) || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/maquina_io_port_if.sv
// Peripheral link of the I/O port: output valid/ready stream and input
// valid/ready stream. master = port side, slave = external peripheral.
interface maquina_io_port_if #(
    parameter int W = maquina_pkg::WORD_W
) ();
    logic [W-1:0] pout_data;
    logic         pout_valid;
    logic         pout_ready;
    logic [W-1:0] pin_data;
    logic         pin_valid;
    logic         pin_ready;

    modport master (
        output pout_data, pout_valid, pin_ready,
        input  pout_ready, pin_data, pin_valid
    );

    modport slave (
        input  pout_data, pout_valid, pin_ready,
        output pout_ready, pin_data, pin_valid
    );
endinterface

// File: rtl/maquina_io_port_fifo.sv
// io_sync_fifo: small synchronous FIFO with registered storage and a head word
// read straight from the storage array. Pointers carry one extra wrap bit so
// full and empty are distinguishable. The caller only issues legal push/pop.
module io_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    // Pointer advance on push/pop; natural wrap of the extra bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/maquina_io_port.sv
// maquina_io_port: OUT path pushes datapath words into an output FIFO that
// drains over pout_*; IN path captures pin_* into a one-entry holding register
// that the control unit reads onto dbus_out. Saturating drop/underrun counters.
// Optional IO_LOOPBACK_EN adds lb_mode, routing the FIFO head into the holding
// register and silencing the external handshakes.
module maquina_io_port
    import maquina_pkg::*;
#(
    parameter int WORD_W    = maquina_pkg::WORD_W,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
`ifdef IO_LOOPBACK_EN
    input  logic              lb_mode,
`endif
    input  logic              out_we,
    input  logic              in_re,
    input  logic [WORD_W-1:0] dbus_in,
    output logic [WORD_W-1:0] dbus_out,
    maquina_io_port_if.master pio,
    output logic              out_full,
    output logic              in_avail,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  undr_cnt
);
    logic              lb_active;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;

    hold_state_t       hold_state_q, hold_state_d;
    logic [WORD_W-1:0] hold_data_q, hold_data_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  undr_cnt_q, undr_cnt_d;

`ifdef IO_LOOPBACK_EN
    logic lb_q, lb_d;

    // Mode change is registered so it takes effect on the following cycle.
    always_comb lb_d = lb_mode;

    // Loopback mode register.
    always_ff @(posedge clk) begin
        if (reset) lb_q <= 1'b0;
        else       lb_q <= lb_d;
    end

    assign lb_active = lb_q;
`else
    assign lb_active = 1'b0;
`endif

    io_sync_fifo #(.W(WORD_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dbus_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // FIFO handshake: pop to the peripheral or to the holding register in
    // loopback; a same-cycle pop frees the slot for a push when full.
    always_comb begin
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        if (lb_active) fifo_pop = (hold_state_q == HOLD_EMPTY) && !fifo_empty;
        else           fifo_pop = !fifo_empty && pio.pout_ready;
        fifo_push = out_we && (!fifo_full || fifo_pop);
    end

    // Holding-register FSM and saturating counters, next-state logic.
    always_comb begin
        hold_state_d = hold_state_q;
        hold_data_d  = hold_data_q;
        drop_cnt_d   = drop_cnt_q;
        undr_cnt_d   = undr_cnt_q;
        case (hold_state_q)
            HOLD_EMPTY: begin
                if (lb_active) begin
                    if (!fifo_empty) begin
                        hold_state_d = HOLD_FULL;
                        hold_data_d  = fifo_head;
                    end
                end else if (pio.pin_valid) begin
                    hold_state_d = HOLD_FULL;
                    hold_data_d  = pio.pin_data;
                end
            end
            HOLD_FULL: begin
                if (in_re) hold_state_d = HOLD_EMPTY;
            end
            default: hold_state_d = HOLD_EMPTY;
        endcase
        if (out_we && !fifo_push && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;
        if (in_re && (hold_state_q == HOLD_EMPTY) && (undr_cnt_q != '1))
            undr_cnt_d = undr_cnt_q + 1'b1;
    end

    // State, holding data and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_state_q <= HOLD_EMPTY;
            hold_data_q  <= '0;
            drop_cnt_q   <= '0;
            undr_cnt_q   <= '0;
        end else begin
            hold_state_q <= hold_state_d;
            hold_data_q  <= hold_data_d;
            drop_cnt_q   <= drop_cnt_d;
            undr_cnt_q   <= undr_cnt_d;
        end
    end

    assign pio.pout_data  = fifo_head;
    assign pio.pout_valid = !fifo_empty && !lb_active;
    assign pio.pin_ready  = (hold_state_q == HOLD_EMPTY) && !lb_active;
    assign out_full       = fifo_full;
    assign in_avail       = (hold_state_q == HOLD_FULL);
    assign dbus_out       = (hold_state_q == HOLD_FULL) ? hold_data_q : '0;
    assign drop_cnt       = drop_cnt_q;
    assign undr_cnt       = undr_cnt_q;
endmodule

// File: tb/tb_maquina_io_port.sv
// Testbench for maquina_io_port: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the port.
module tb_maquina_io_port;
    import maquina_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          out_we, in_re, lb_mode;
    logic [W-1:0]  dbus_in, dbus_out, last_dbus;
    logic          out_full, in_avail;
    logic [CW-1:0] drop_cnt, undr_cnt;

    maquina_io_port_if #(.W(W)) pio ();

    always #5 clk = ~clk;

    maquina_io_port #(.WORD_W(W), .OUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef IO_LOOPBACK_EN
        .lb_mode  (lb_mode),
`endif
        .out_we   (out_we),
        .in_re    (in_re),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .pio      (pio.master),
        .out_full (out_full),
        .in_avail (in_avail),
        .drop_cnt (drop_cnt),
        .undr_cnt (undr_cnt)
    );

    // Reference model: FIFO as a queue, holding register as a flag plus word.
    logic [W-1:0] m_q[$];
    bit           m_full;
    logic [W-1:0] m_val;
    int           m_drop, m_undr;
    bit           m_lb;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = !m_lb && (m_q.size() > 0);
        chk("pout_valid", 32'(pio.pout_valid), 32'(exp_valid));
        if (exp_valid) chk("pout_data", 32'(pio.pout_data), 32'(m_q[0]));
        chk("out_full",  32'(out_full),      32'(m_q.size() == DEPTH));
        chk("pin_ready", 32'(pio.pin_ready), 32'(!m_lb && !m_full));
        chk("in_avail",  32'(in_avail),      32'(m_full));
        chk("dbus_out",  32'(dbus_out),      32'(m_full ? m_val : '0));
        chk("drop_cnt",  32'(drop_cnt),      32'(m_drop));
        chk("undr_cnt",  32'(undr_cnt),      32'(m_undr));
    endtask

    // One clock: drive inputs at the negedge, update the model, check next negedge.
    task automatic step(input bit we, input logic [W-1:0] din, input bit re,
                        input bit prdy, input bit pvld, input logic [W-1:0] pdata);
        bit           pop, push_ok;
        logic [W-1:0] head;
        out_we = we; dbus_in = din; in_re = re;
        pio.pout_ready = prdy; pio.pin_valid = pvld; pio.pin_data = pdata;
        #1;
        last_dbus = dbus_out;
        chk("dbus_out_live", 32'(dbus_out), 32'(m_full ? m_val : '0));
        head = (m_q.size() > 0) ? m_q[0] : '0;
        if (m_lb) pop = !m_full && (m_q.size() > 0);
        else      pop = prdy && (m_q.size() > 0);
        push_ok = we && ((m_q.size() < DEPTH) || pop);
        if (we && !push_ok && m_drop < 255) m_drop++;
        if (re && !m_full && m_undr < 255) m_undr++;
        if (!m_full) begin
            if (m_lb) begin
                if (pop) begin m_full = 1'b1; m_val = head; end
            end else if (pvld) begin
                m_full = 1'b1; m_val = pdata;
            end
        end else if (re) begin
            m_full = 1'b0;
        end
        if (pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(din);
        m_lb = lb_mode;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Reset with busy-looking inputs: nothing may complete during the reset cycle.
    task automatic do_reset();
        reset = 1'b1; out_we = 1'b1; in_re = 1'b1;
        pio.pout_ready = 1'b1; pio.pin_valid = 1'b1;
        pio.pin_data = W'($urandom); dbus_in = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; out_we = 1'b0; in_re = 1'b0;
        pio.pin_valid = 1'b0; pio.pout_ready = 1'b0;
        m_q.delete(); m_full = 1'b0; m_val = '0; m_drop = 0; m_undr = 0; m_lb = 1'b0;
        check_outputs();
    endtask

    initial begin
        reset = 1'b1; out_we = 1'b0; in_re = 1'b0; lb_mode = 1'b0;
        dbus_in = '0; last_dbus = '0;
        pio.pout_ready = 1'b0; pio.pin_valid = 1'b0; pio.pin_data = '0;
        @(negedge clk);
        do_reset();

        // Reset state.
        chk("t1_pout_valid", 32'(pio.pout_valid), 32'(0));
        chk("t1_pin_ready",  32'(pio.pin_ready),  32'(1));
        chk("t1_dbus_out",   32'(dbus_out),       32'(0));
        chk("t1_drop_cnt",   32'(drop_cnt),       32'(0));
        chk("t1_undr_cnt",   32'(undr_cnt),       32'(0));

        // OUT stream into a stalled peripheral, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0, 1'b0, '0);
            if (i == 4) chk("t2_full_after4", 32'(out_full), 32'(1));
        end
        chk("t2_drop_cnt", 32'(drop_cnt), 32'(1));
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain_word", 32'(pio.pout_data), 32'(i));
            step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        end
        chk("t2_drained", 32'(pio.pout_valid), 32'(0));

        // Push and pop together while full, then saturate the drop counter.
        for (int i = 0; i < 4; i++) step(1'b1, W'(16'h0010 + i), 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, '0);
        chk("t3_still_full", 32'(out_full), 32'(1));
        chk("t3_next_head",  32'(pio.pout_data), 32'(16'h0011));
        for (int i = 0; i < 300; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0, '0);
        chk("t3_drop_sat", 32'(drop_cnt), 32'(8'hFF));

        // IN capture and consume.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        chk("t4_pin_ready", 32'(pio.pin_ready), 32'(0));
        chk("t4_in_avail",  32'(in_avail),      32'(1));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("t4_dbus_in_re", 32'(last_dbus),     32'(16'hBEEF));
        chk("t4_in_avail0",  32'(in_avail),      32'(0));
        chk("t4_pin_ready1", 32'(pio.pin_ready), 32'(1));

        // Underrun, then reset while busy.
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("t5_dbus_underrun", 32'(last_dbus), 32'(0));
        chk("t5_undr_cnt",      32'(undr_cnt),  32'(1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h5555);
        for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0, '0);
        do_reset();
        chk("t5_rst_valid", 32'(pio.pout_valid), 32'(0));
        chk("t5_rst_avail", 32'(in_avail),       32'(0));
        chk("t5_rst_full",  32'(out_full),       32'(0));

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, W'($urandom));
        end

`ifdef IO_LOOPBACK_EN
        // Loopback: FIFO head lands in the holding register.
        do_reset();
        lb_mode = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, '0);
        chk("t6_avail_1cyc", 32'(in_avail), 32'(0));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t6_avail_2cyc", 32'(in_avail),       32'(1));
        chk("t6_pout_valid", 32'(pio.pout_valid), 32'(0));
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        chk("t6_dbus_lb",    32'(last_dbus),      32'(16'h1234));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) lb_mode = ~lb_mode;
            step($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, W'($urandom));
        end
        lb_mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
